// File: rtl/iter_mult_div.sv
// -----------------------------------------------------------------------------
// iter_mult_div
//   Iterative integer multiply / divide unit with a valid/ready request side and
//   a valid/ready result side. One operation is in flight at a time.
//
//   Operations (op): 00 MULTU, 01 MULT, 10 DIVU, 11 DIV.
//   Multiply returns the full 2*WIDTH product {hi, lo}; divide returns
//   {remainder, quotient} with truncating semantics (remainder follows the
//   dividend). Divide-by-zero yields quotient all ones, remainder = dividend,
//   and raises div_by_zero.
//
//   Ports:
//     clk, rst_n      clock, asynchronous active-low reset
//     flush           synchronous abort of any operation in flight
//     start_valid/_ready, op, operand_1, operand_2   request channel
//     result_valid/_ready, result, div_by_zero       result channel
//
//   Parameters:
//     WIDTH     operand width (even, 8..64)
//     MULT_SEQ  0: single-cycle product, 1: shift-add one bit per cycle
// -----------------------------------------------------------------------------
module iter_mult_div #(
  parameter int WIDTH    = 32,
  parameter int MULT_SEQ = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 flush,
  input  logic                 start_valid,
  output logic                 start_ready,
  input  logic [1:0]           op,
  input  logic [WIDTH-1:0]     operand_1,
  input  logic [WIDTH-1:0]     operand_2,
  output logic                 result_valid,
  input  logic                 result_ready,
  output logic [2*WIDTH-1:0]   result,
  output logic                 div_by_zero
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    FIX  = 2'b10,
    DONE = 2'b11
  } state_t;

  state_t              state_q;
  logic [CW-1:0]       cnt_q;
  logic                is_div_q;
  logic                neg_q;       // quotient / product sign
  logic                rneg_q;      // remainder sign (dividend sign)
  logic                dbz_q;
  // hi_q/lo_q form a double-width working register:
  //   divide:   hi = partial remainder, lo = dividend shifting into quotient
  //   multiply: hi = upper accumulator, lo = multiplier shifting into product
  // b_q holds the divisor (divide) or the multiplicand (multiply).
  logic [WIDTH-1:0]    hi_q, lo_q, b_q;
  logic                start_ready_q;
  logic                result_valid_q;
  logic [2*WIDTH-1:0]  result_q;
  logic                div_by_zero_q;

  // Operand magnitudes and signs captured at acceptance.
  logic                sign1, sign2;
  logic [WIDTH-1:0]    mag1, mag2;

  always_comb begin
    sign1 = op[0] & operand_1[WIDTH-1];
    sign2 = op[0] & operand_2[WIDTH-1];
    mag1  = sign1 ? (~operand_1 + 1'b1) : operand_1;
    mag2  = sign2 ? (~operand_2 + 1'b1) : operand_2;
  end

  // One CALC iteration of whichever algorithm is running.
  logic [WIDTH:0]      trial;
  logic [WIDTH:0]      sum;
  logic [2*WIDTH-1:0]  prod_full;
  logic [WIDTH-1:0]    hi_d, lo_d;
  logic                calc_last;

  always_comb begin
    // Restoring divide: shift one dividend bit into the partial remainder and
    // try subtracting the divisor; a clear borrow bit means the trial fits.
    trial     = {hi_q, lo_q[WIDTH-1]} - {1'b0, b_q};
    sum       = {1'b0, hi_q} + {1'b0, b_q};
    prod_full = (2*WIDTH)'(b_q) * (2*WIDTH)'(lo_q);
    hi_d      = hi_q;
    lo_d      = lo_q;
    calc_last = 1'b0;
    if (is_div_q) begin
      if (!trial[WIDTH]) begin
        hi_d = trial[WIDTH-1:0];
        lo_d = {lo_q[WIDTH-2:0], 1'b1};
      end else begin
        hi_d = {hi_q[WIDTH-2:0], lo_q[WIDTH-1]};
        lo_d = {lo_q[WIDTH-2:0], 1'b0};
      end
      calc_last = (cnt_q == LAST_ITER);
    end else if (MULT_SEQ != 0) begin
      // Shift-add: conditionally add multiplicand, then shift {carry,hi,lo}
      // right by one; consumed multiplier bits fall off the bottom of lo.
      if (lo_q[0]) begin
        hi_d = sum[WIDTH:1];
        lo_d = {sum[0], lo_q[WIDTH-1:1]};
      end else begin
        hi_d = {1'b0, hi_q[WIDTH-1:1]};
        lo_d = {hi_q[0], lo_q[WIDTH-1:1]};
      end
      calc_last = (cnt_q == LAST_ITER);
    end else begin
      {hi_d, lo_d} = prod_full;
      calc_last    = 1'b1;
    end
  end

  // Sign correction applied in FIX.
  logic [WIDTH-1:0]    quo_fix, rem_fix;
  logic [2*WIDTH-1:0]  fix_result;

  always_comb begin
    // Divide by zero leaves the quotient at all ones regardless of sign; the
    // remainder path naturally restores the original dividend.
    quo_fix = dbz_q ? '1 : (neg_q ? (~lo_q + 1'b1) : lo_q);
    rem_fix = rneg_q ? (~hi_q + 1'b1) : hi_q;
    if (is_div_q) begin
      fix_result = {rem_fix, quo_fix};
    end else begin
      fix_result = neg_q ? (~{hi_q, lo_q} + 1'b1) : {hi_q, lo_q};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      is_div_q       <= 1'b0;
      neg_q          <= 1'b0;
      rneg_q         <= 1'b0;
      dbz_q          <= 1'b0;
      hi_q           <= '0;
      lo_q           <= '0;
      b_q            <= '0;
      start_ready_q  <= 1'b1;
      result_valid_q <= 1'b0;
      result_q       <= '0;
      div_by_zero_q  <= 1'b0;
    end else if (flush) begin
      state_q        <= IDLE;
      start_ready_q  <= 1'b1;
      result_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_valid) begin
            state_q       <= CALC;
            start_ready_q <= 1'b0;
            cnt_q         <= '0;
            is_div_q      <= op[1];
            neg_q         <= sign1 ^ sign2;
            rneg_q        <= sign1;
            dbz_q         <= op[1] & (operand_2 == '0);
            hi_q          <= '0;
            lo_q          <= op[1] ? mag1 : mag2;
            b_q           <= op[1] ? mag2 : mag1;
          end
        end
        CALC: begin
          hi_q  <= hi_d;
          lo_q  <= lo_d;
          cnt_q <= cnt_q + CW'(1);
          if (calc_last) begin
            state_q <= FIX;
          end
        end
        FIX: begin
          result_q       <= fix_result;
          div_by_zero_q  <= dbz_q;
          state_q        <= DONE;
          result_valid_q <= 1'b1;
        end
        DONE: begin
          if (result_ready) begin
            state_q        <= IDLE;
            result_valid_q <= 1'b0;
            start_ready_q  <= 1'b1;
          end
        end
        default: begin
          state_q        <= IDLE;
          result_valid_q <= 1'b0;
          start_ready_q  <= 1'b1;
        end
      endcase
    end
  end

  assign start_ready  = start_ready_q;
  assign result_valid = result_valid_q;
  assign result       = result_q;
  assign div_by_zero  = div_by_zero_q;

endmodule

// File: tb/tb_iter_mult_div.sv
// -----------------------------------------------------------------------------
// tb_iter_mult_div
//   Directed bench for iter_mult_div at WIDTH=32. Instance dut uses the
//   single-cycle multiplier, dut_s the shift-add multiplier. Each scenario task
//   drives its own stimulus and compares against hand-computed values.
// -----------------------------------------------------------------------------
module tb_iter_mult_div;
  localparam int W = 32;

  logic           clk = 1'b0;
  logic           rst_n = 1'b1;
  logic           flush = 1'b0;
  logic [1:0]     op = 2'b00;
  logic [W-1:0]   a = '0;
  logic [W-1:0]   b = '0;
  logic           sv0 = 1'b0, sv1 = 1'b0;
  logic           rr0 = 1'b0, rr1 = 1'b0;
  logic           sr0, sr1, rv0, rv1, dz0, dz1;
  logic [2*W-1:0] res0, res1;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  iter_mult_div #(.WIDTH(W), .MULT_SEQ(0)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .start_valid(sv0), .start_ready(sr0), .op(op),
    .operand_1(a), .operand_2(b),
    .result_valid(rv0), .result_ready(rr0),
    .result(res0), .div_by_zero(dz0)
  );

  iter_mult_div #(.WIDTH(W), .MULT_SEQ(1)) dut_s (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .start_valid(sv1), .start_ready(sr1), .op(op),
    .operand_1(a), .operand_2(b),
    .result_valid(rv1), .result_ready(rr1),
    .result(res1), .div_by_zero(dz1)
  );

  // Directed vectors: {op, operand_1, operand_2} -> {result, div_by_zero}
  logic [1:0]     dv_op [5] = '{2'd3, 2'd3, 2'd2, 2'd2, 2'd3};
  logic [W-1:0]   dv_a  [5] = '{32'hFFFFFFF9, 32'h00000007, 32'h00000064, 32'hFFFFFFFF, 32'hFFFFFF9C};
  logic [W-1:0]   dv_b  [5] = '{32'h00000002, 32'hFFFFFFFE, 32'h00000007, 32'h00000010, 32'h00000007};
  logic [2*W-1:0] dv_r  [5] = '{64'hFFFFFFFF_FFFFFFFD, 64'h00000001_FFFFFFFD, 64'h00000002_0000000E,
                               64'h0000000F_0FFFFFFF, 64'hFFFFFFFE_FFFFFFF2};

  logic [1:0]     ds_op [4] = '{2'd2, 2'd3, 2'd3, 2'd3};
  logic [W-1:0]   ds_a  [4] = '{32'h0000000A, 32'hFFFFFFF9, 32'h80000000, 32'h80000000};
  logic [W-1:0]   ds_b  [4] = '{32'h00000000, 32'h00000000, 32'hFFFFFFFF, 32'h00000000};
  logic [2*W-1:0] ds_r  [4] = '{64'h0000000A_FFFFFFFF, 64'hFFFFFFF9_FFFFFFFF, 64'h00000000_80000000,
                               64'h80000000_FFFFFFFF};
  logic           ds_z  [4] = '{1'b1, 1'b1, 1'b0, 1'b1};

  logic [1:0]     mv_op [6] = '{2'd0, 2'd1, 2'd1, 2'd0, 2'd1, 2'd1};
  logic [W-1:0]   mv_a  [6] = '{32'hFFFFFFFF, 32'hFFFFFFFE, 32'h80000000, 32'h12345678, 32'hFFFFFFFF, 32'h00000005};
  logic [W-1:0]   mv_b  [6] = '{32'hFFFFFFFF, 32'h00000003, 32'h80000000, 32'h00000010, 32'hFFFFFFFF, 32'hFFFFFFFD};
  logic [2*W-1:0] mv_r  [6] = '{64'hFFFFFFFE_00000001, 64'hFFFFFFFF_FFFFFFFA, 64'h40000000_00000000,
                               64'h00000001_23456780, 64'h00000000_00000001, 64'hFFFFFFFF_FFFFFFF1};

  // Runs one transaction on the selected instance. Latency counts the
  // acceptance edge as 1 and each further edge until result_valid is seen.
  // Operands are scrambled right after acceptance to show they were captured.
  task automatic do_op(input bit sel, input logic [1:0] o, input logic [W-1:0] x,
                       input logic [W-1:0] y, output logic [2*W-1:0] r,
                       output logic dz, output int lat);
    int guard;
    @(negedge clk);
    guard = 0;
    while (!(sel ? sr1 : sr0) && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    op = o; a = x; b = y;
    if (sel) sv1 = 1'b1; else sv0 = 1'b1;
    @(posedge clk);
    lat = 1;
    #1;
    sv0 = 1'b0; sv1 = 1'b0;
    a = W'($urandom); b = W'($urandom); op = 2'($urandom);
    while (!(sel ? rv1 : rv0) && lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
    end
    r  = sel ? res1 : res0;
    dz = sel ? dz1 : dz0;
    @(negedge clk);
    if (sel) rr1 = 1'b1; else rr0 = 1'b1;
    @(posedge clk);
    #1;
    rr0 = 1'b0; rr1 = 1'b0;
  endtask

  task automatic test_reset();
    int guard;
    #3 rst_n = 1'b0;
    @(negedge clk);
    checks += 4;
    if (sr0 !== 1'b1) begin errors++; $display("FAIL reset start_ready: got %b expected 1", sr0); end
    if (rv0 !== 1'b0) begin errors++; $display("FAIL reset result_valid: got %b expected 0", rv0); end
    if (res0 !== '0) begin errors++; $display("FAIL reset result: got %h expected 0", res0); end
    if (dz0 !== 1'b0) begin errors++; $display("FAIL reset div_by_zero: got %b expected 0", dz0); end
    // First request must be taken on the first rising edge after release.
    rst_n = 1'b1;
    op = 2'd0; a = 32'd3; b = 32'd5; sv0 = 1'b1;
    @(posedge clk);
    #1 sv0 = 1'b0;
    checks++;
    if (sr0 !== 1'b0) begin errors++; $display("FAIL first_accept start_ready: got %b expected 0", sr0); end
    guard = 0;
    while (!rv0 && guard < 100) begin @(posedge clk); #1; guard++; end
    checks++;
    if (res0 !== 64'd15) begin errors++; $display("FAIL first_accept result: got %h expected %h", res0, 64'd15); end
    @(negedge clk) rr0 = 1'b1;
    @(posedge clk) #1 rr0 = 1'b0;
    $display("reset: outputs checked, first request MULTU 3*5 -> %h", res0);
  endtask

  task automatic test_divide();
    logic [2*W-1:0] r;
    logic dz;
    int lat;
    for (int i = 0; i < 5; i++) begin
      do_op(1'b0, dv_op[i], dv_a[i], dv_b[i], r, dz, lat);
      checks += 3;
      if (r !== dv_r[i]) begin errors++; $display("FAIL div[%0d] result: got %h expected %h", i, r, dv_r[i]); end
      if (dz !== 1'b0) begin errors++; $display("FAIL div[%0d] div_by_zero: got %b expected 0", i, dz); end
      if (lat != 34) begin errors++; $display("FAIL div[%0d] latency: got %0d expected 34", i, lat); end
      $display("div op=%0d %h / %h -> %h dbz=%b lat=%0d", dv_op[i], dv_a[i], dv_b[i], r, dz, lat);
    end
  endtask

  task automatic test_div_special();
    logic [2*W-1:0] r;
    logic dz;
    int lat;
    for (int i = 0; i < 4; i++) begin
      do_op(1'b0, ds_op[i], ds_a[i], ds_b[i], r, dz, lat);
      checks += 3;
      if (r !== ds_r[i]) begin errors++; $display("FAIL divspec[%0d] result: got %h expected %h", i, r, ds_r[i]); end
      if (dz !== ds_z[i]) begin errors++; $display("FAIL divspec[%0d] div_by_zero: got %b expected %b", i, dz, ds_z[i]); end
      if (lat != 34) begin errors++; $display("FAIL divspec[%0d] latency: got %0d expected 34", i, lat); end
      $display("divspec op=%0d %h / %h -> %h dbz=%b lat=%0d", ds_op[i], ds_a[i], ds_b[i], r, dz, lat);
    end
  endtask

  task automatic test_multiply();
    logic [2*W-1:0] r;
    logic dz;
    int lat;
    int exp_lat;
    for (int s = 0; s < 2; s++) begin
      exp_lat = (s == 0) ? 3 : 34;
      for (int i = 0; i < 6; i++) begin
        do_op(s[0], mv_op[i], mv_a[i], mv_b[i], r, dz, lat);
        checks += 3;
        if (r !== mv_r[i]) begin errors++; $display("FAIL mul%0d[%0d] result: got %h expected %h", s, i, r, mv_r[i]); end
        if (dz !== 1'b0) begin errors++; $display("FAIL mul%0d[%0d] div_by_zero: got %b expected 0", s, i, dz); end
        if (lat != exp_lat) begin errors++; $display("FAIL mul%0d[%0d] latency: got %0d expected %0d", s, i, lat, exp_lat); end
        $display("mul seq=%0d op=%0d %h * %h -> %h lat=%0d", s, mv_op[i], mv_a[i], mv_b[i], r, lat);
      end
    end
  endtask

  task automatic test_backpressure();
    int guard;
    @(negedge clk);
    op = 2'd2; a = 32'd10; b = 32'd0; sv0 = 1'b1;
    @(posedge clk);
    #1 sv0 = 1'b0;
    guard = 0;
    while (!rv0 && guard < 100) begin @(posedge clk); #1; guard++; end
    checks += 2;
    if (res0 !== 64'h0000000A_FFFFFFFF) begin errors++; $display("FAIL bp result: got %h expected %h", res0, 64'h0000000A_FFFFFFFF); end
    if (dz0 !== 1'b1) begin errors++; $display("FAIL bp div_by_zero: got %b expected 1", dz0); end
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      #1;
      checks += 4;
      if (rv0 !== 1'b1) begin errors++; $display("FAIL bp[%0d] result_valid: got %b expected 1", c, rv0); end
      if (res0 !== 64'h0000000A_FFFFFFFF) begin errors++; $display("FAIL bp[%0d] result: got %h expected %h", c, res0, 64'h0000000A_FFFFFFFF); end
      if (dz0 !== 1'b1) begin errors++; $display("FAIL bp[%0d] div_by_zero: got %b expected 1", c, dz0); end
      if (sr0 !== 1'b0) begin errors++; $display("FAIL bp[%0d] start_ready: got %b expected 0", c, sr0); end
    end
    // Take the result while also offering a new request: it must not be taken.
    @(negedge clk);
    rr0 = 1'b1; sv0 = 1'b1; op = 2'd0; a = 32'd1; b = 32'd1;
    @(posedge clk);
    #1 rr0 = 1'b0; sv0 = 1'b0;
    checks += 2;
    if (rv0 !== 1'b0) begin errors++; $display("FAIL bp_take result_valid: got %b expected 0", rv0); end
    if (sr0 !== 1'b1) begin errors++; $display("FAIL bp_take start_ready: got %b expected 1", sr0); end
    $display("backpressure: held 5 cycles, then taken, start_ready=%b", sr0);
  endtask

  task automatic test_flush();
    logic [2*W-1:0] r;
    logic dz;
    int lat;
    int seen;
    @(negedge clk);
    op = 2'd3; a = 32'hFFFFFFF9; b = 32'd2; sv0 = 1'b1;
    @(posedge clk);
    #1 sv0 = 1'b0;
    repeat (9) @(posedge clk);   // now in the 10th CALC cycle
    @(negedge clk) flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    checks += 2;
    if (sr0 !== 1'b1) begin errors++; $display("FAIL flush start_ready: got %b expected 1", sr0); end
    if (rv0 !== 1'b0) begin errors++; $display("FAIL flush result_valid: got %b expected 0", rv0); end
    // flush wins over a simultaneous request
    @(negedge clk);
    flush = 1'b1; sv0 = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0; sv0 = 1'b0;
    checks++;
    if (sr0 !== 1'b1) begin errors++; $display("FAIL flush_prio start_ready: got %b expected 1", sr0); end
    seen = 0;
    for (int c = 0; c < 40; c++) begin @(posedge clk); #1; if (rv0) seen++; end
    checks++;
    if (seen != 0) begin errors++; $display("FAIL flush ghost result_valid: got %0d cycles expected 0", seen); end
    do_op(1'b0, 2'd2, 32'd100, 32'd7, r, dz, lat);
    checks++;
    if (r !== 64'h00000002_0000000E) begin errors++; $display("FAIL flush_next result: got %h expected %h", r, 64'h00000002_0000000E); end
    $display("flush: aborted DIV, next DIVU 100/7 -> %h", r);
  endtask

  task automatic test_reset_midop();
    logic [2*W-1:0] r;
    logic dz;
    int lat;
    int seen;
    do_op(1'b0, 2'd2, 32'd10, 32'd0, r, dz, lat);   // leaves nonzero result and dbz=1
    @(negedge clk);
    op = 2'd3; a = 32'hFFFFFFF9; b = 32'd2; sv0 = 1'b1;
    @(posedge clk);
    #1 sv0 = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk) rst_n = 1'b0;
    #1;
    checks += 4;
    if (sr0 !== 1'b1) begin errors++; $display("FAIL rstmid start_ready: got %b expected 1", sr0); end
    if (rv0 !== 1'b0) begin errors++; $display("FAIL rstmid result_valid: got %b expected 0", rv0); end
    if (res0 !== '0) begin errors++; $display("FAIL rstmid result: got %h expected 0", res0); end
    if (dz0 !== 1'b0) begin errors++; $display("FAIL rstmid div_by_zero: got %b expected 0", dz0); end
    @(negedge clk) rst_n = 1'b1;
    seen = 0;
    for (int c = 0; c < 40; c++) begin @(posedge clk); #1; if (rv0) seen++; end
    checks++;
    if (seen != 0) begin errors++; $display("FAIL rstmid ghost result_valid: got %0d cycles expected 0", seen); end
    $display("reset mid-op: outputs cleared, no result followed");
  endtask

  initial begin
    test_reset();
    test_divide();
    test_div_special();
    test_multiply();
    test_backpressure();
    test_flush();
    test_reset_midop();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1, "watchdog");
  end

endmodule
